// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversampled SCLK/SS_N/MOSI, MSB-first 8-bit frames, single-entry tx buffer.
// Optional status pulses (o_underrun, o_abort) enabled by defining SPI_SLAVE_STATUS_EN.
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEFAULT_TX  = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_sclk,
    input  logic       i_ss_n,
    input  logic       i_mosi,
    output logic       o_miso,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_busy
`ifdef SPI_SLAVE_STATUS_EN
    ,
    output logic       o_underrun,
    output logic       o_abort
`endif
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned WARM_W = SYNC_STAGES + 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_d, ss_d;
    logic [WARM_W-1:0]      warm;
    logic                   armed;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    logic [0:0]        state, nxt_state;
    logic [BYTE_W-1:0] tx_buf, nxt_tx_buf;
    logic              tx_empty, nxt_tx_empty;
    logic [BYTE_W-1:0] tx_shift, nxt_tx_shift;
    logic [BYTE_W-1:0] rx_shift, nxt_rx_shift;
    logic [CNT_W-1:0]  bit_cnt, nxt_bit_cnt;
    logic              boundary, nxt_boundary;
    logic              miso, nxt_miso;
    logic [BYTE_W-1:0] rx_data, nxt_rx_data;
    logic              rx_valid, nxt_rx_valid;
    logic              busy, nxt_busy;
    logic              do_load;
    logic [BYTE_W-1:0] load_byte;
`ifdef SPI_SLAVE_STATUS_EN
    logic              underrun, nxt_underrun;
    logic              abort_q, nxt_abort;
`endif

    // Input synchronizers, one-cycle-delayed copies and post-reset warm-up
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
            warm      <= '0;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], i_ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
            warm      <= {warm[WARM_W-2:0], 1'b1};
            // A select already low at reset release must go high before a frame can start
            armed     <= armed | (warm[WARM_W-1] & ss_s);
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_rise   = ss_s & ~ss_d;
    assign ss_fall   = ~ss_s & ss_d;
    assign load_byte = tx_empty ? DEFAULT_TX : tx_buf;

    // State and output registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= ST_IDLE;
            tx_buf   <= '0;
            tx_empty <= 1'b1;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            boundary <= 1'b0;
            miso     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
            underrun <= 1'b0;
            abort_q  <= 1'b0;
`endif
        end else begin
            state    <= nxt_state;
            tx_buf   <= nxt_tx_buf;
            tx_empty <= nxt_tx_empty;
            tx_shift <= nxt_tx_shift;
            rx_shift <= nxt_rx_shift;
            bit_cnt  <= nxt_bit_cnt;
            boundary <= nxt_boundary;
            miso     <= nxt_miso;
            rx_data  <= nxt_rx_data;
            rx_valid <= nxt_rx_valid;
            busy     <= nxt_busy;
`ifdef SPI_SLAVE_STATUS_EN
            underrun <= nxt_underrun;
            abort_q  <= nxt_abort;
`endif
        end
    end

    // Next-state and output logic
    always_comb begin
        nxt_state    = state;
        nxt_tx_buf   = tx_buf;
        nxt_tx_empty = tx_empty;
        nxt_tx_shift = tx_shift;
        nxt_rx_shift = rx_shift;
        nxt_bit_cnt  = bit_cnt;
        nxt_boundary = boundary;
        nxt_miso     = miso;
        nxt_rx_data  = rx_data;
        nxt_rx_valid = 1'b0;
        nxt_busy     = busy;
        do_load      = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
        nxt_underrun = 1'b0;
        nxt_abort    = 1'b0;
`endif

        case (state)
            ST_IDLE: begin
                nxt_busy = 1'b0;
                nxt_miso = 1'b0;
                if (armed && ss_fall) begin
                    do_load      = 1'b1;
                    nxt_state    = ST_ACTIVE;
                    nxt_busy     = 1'b1;
                    nxt_bit_cnt  = '0;
                    nxt_boundary = 1'b0;
                    nxt_rx_shift = '0;
                end
            end
            ST_ACTIVE: begin
                nxt_busy = 1'b1;
                // Select release takes priority over any coincident SCLK edge
                if (ss_rise) begin
                    nxt_state    = ST_IDLE;
                    nxt_busy     = 1'b0;
                    nxt_miso     = 1'b0;
                    nxt_bit_cnt  = '0;
                    nxt_boundary = 1'b0;
                    nxt_rx_shift = '0;
`ifdef SPI_SLAVE_STATUS_EN
                    nxt_abort    = (bit_cnt != '0);
`endif
                end else if (sclk_rise) begin
                    nxt_rx_shift = {rx_shift[BYTE_W-2:0], mosi_s};
                    nxt_bit_cnt  = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                        nxt_rx_data  = {rx_shift[BYTE_W-2:0], mosi_s};
                        nxt_rx_valid = 1'b1;
                        nxt_boundary = 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (boundary) begin
                        do_load      = 1'b1;
                        nxt_boundary = 1'b0;
                    end else begin
                        nxt_tx_shift = {tx_shift[BYTE_W-2:0], 1'b0};
                        nxt_miso     = tx_shift[BYTE_W-2];
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase

        // Loads sample the buffer as it stood before any same-cycle write
        if (do_load) begin
            nxt_tx_shift = load_byte;
            nxt_miso     = load_byte[BYTE_W-1];
            if (!tx_empty)
                nxt_tx_empty = 1'b1;
`ifdef SPI_SLAVE_STATUS_EN
            nxt_underrun = tx_empty;
`endif
        end
        if (i_tx_valid && tx_empty) begin
            nxt_tx_buf   = i_tx_data;
            nxt_tx_empty = 1'b0;
        end
    end

    assign o_miso     = miso;
    assign o_tx_ready = tx_empty;
    assign o_rx_data  = rx_data;
    assign o_rx_valid = rx_valid;
    assign o_busy     = busy;
`ifdef SPI_SLAVE_STATUS_EN
    assign o_underrun = underrun;
    assign o_abort    = abort_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural mode-0 master at i_clk/8 with hand-computed expectations.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
`ifdef SPI_SLAVE_STATUS_EN
    logic       underrun;
    logic       abort_p;
    int         underrun_cnt = 0;
    int         abort_cnt = 0;
    int         ur0, ab0;
`endif

    int         checks = 0;
    int         errors = 0;
    int         rx_cnt = 0;
    int         miso_hi = 0;
    logic       watch = 1'b0;
    logic [7:0] rx_hist [0:63];
    int         rx0;
    logic [7:0] got, got2;

    spi_slave #(.SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_sclk     (sclk),
        .i_ss_n     (ss_n),
        .i_mosi     (mosi),
        .o_miso     (miso),
        .i_tx_data  (tx_data),
        .i_tx_valid (tx_valid),
        .o_tx_ready (tx_ready),
        .o_rx_data  (rx_data),
        .o_rx_valid (rx_valid),
        .o_busy     (busy)
`ifdef SPI_SLAVE_STATUS_EN
        ,
        .o_underrun (underrun),
        .o_abort    (abort_p)
`endif
    );

    always #5 clk = ~clk;

    // Observe strobes on the falling clock edge
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_hist[rx_cnt % 64] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (watch && miso)
            miso_hi <= miso_hi + 1;
`ifdef SPI_SLAVE_STATUS_EN
        if (underrun) underrun_cnt <= underrun_cnt + 1;
        if (abort_p)  abort_cnt <= abort_cnt + 1;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
    endtask

    task automatic start_frame();
        ss_n = 1'b0;
        cyc(8);
    endtask

    // Final SCLK fall coincides with SS_N rise so no extra byte load occurs
    task automatic end_frame();
        sclk = 1'b0;
        ss_n = 1'b1;
        cyc(10);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, input bit last, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            cyc(4);
            rx[i] = miso;
            sclk = 1'b1;
            cyc(4);
            if (!(last && i == 8 - nbits))
                sclk = 1'b0;
        end
    endtask

    initial begin
        cyc(2);
        chk("rst_miso", 32'(miso), 32'h0);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_rx_valid", 32'(rx_valid), 32'h0);
        chk("rst_tx_ready", 32'(tx_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
`ifdef SPI_SLAVE_STATUS_EN
        chk("rst_underrun", 32'(underrun), 32'h0);
        chk("rst_abort", 32'(abort_p), 32'h0);
`endif
        rst_n = 1'b1;
        cyc(10);

        // Preloaded byte, single frame
        preload(8'hA5);
        chk("t1_ready_low", 32'(tx_ready), 32'h0);
        rx0 = rx_cnt;
`ifdef SPI_SLAVE_STATUS_EN
        ur0 = underrun_cnt;
`endif
        start_frame();
        chk("t1_ready_at_ss", 32'(tx_ready), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        xfer(8'h3C, 8, 1'b1, got);
        end_frame();
        chk("t1_miso_byte", 32'(got), 32'hA5);
        chk("t1_rx_count", 32'(rx_cnt - rx0), 32'd1);
        chk("t1_rx_data", 32'(rx_hist[rx0]), 32'h3C);
        chk("t1_busy_end", 32'(busy), 32'h0);
        chk("t1_miso_idle", 32'(miso), 32'h0);
`ifdef SPI_SLAVE_STATUS_EN
        chk("t1_underrun", 32'(underrun_cnt - ur0), 32'd0);
`endif

        // Underrun uses DEFAULT_TX
        rx0 = rx_cnt;
`ifdef SPI_SLAVE_STATUS_EN
        ur0 = underrun_cnt;
`endif
        start_frame();
        xfer(8'h01, 8, 1'b1, got);
        end_frame();
        chk("t2_miso_byte", 32'(got), 32'hFF);
        chk("t2_rx_count", 32'(rx_cnt - rx0), 32'd1);
        chk("t2_rx_data", 32'(rx_hist[rx0]), 32'h01);
`ifdef SPI_SLAVE_STATUS_EN
        chk("t2_underrun", 32'(underrun_cnt - ur0), 32'd1);
`endif

        // Two-byte frame with the second byte written mid-frame
        preload(8'h11);
        rx0 = rx_cnt;
`ifdef SPI_SLAVE_STATUS_EN
        ur0 = underrun_cnt;
`endif
        start_frame();
        preload(8'h22);
        chk("t3_ready_low", 32'(tx_ready), 32'h0);
        xfer(8'hC3, 8, 1'b0, got);
        xfer(8'h5A, 8, 1'b1, got2);
        end_frame();
        chk("t3_miso_b0", 32'(got), 32'h11);
        chk("t3_miso_b1", 32'(got2), 32'h22);
        chk("t3_rx_count", 32'(rx_cnt - rx0), 32'd2);
        chk("t3_rx_b0", 32'(rx_hist[rx0]), 32'hC3);
        chk("t3_rx_b1", 32'(rx_hist[rx0+1]), 32'h5A);
        chk("t3_ready_end", 32'(tx_ready), 32'h1);
`ifdef SPI_SLAVE_STATUS_EN
        chk("t3_underrun", 32'(underrun_cnt - ur0), 32'd0);
`endif

        // Abort after five rising edges, then a clean frame
        rx0 = rx_cnt;
`ifdef SPI_SLAVE_STATUS_EN
        ab0 = abort_cnt;
`endif
        start_frame();
        xfer(8'hF0, 5, 1'b1, got);
        end_frame();
        chk("t4_rx_count", 32'(rx_cnt - rx0), 32'd0);
        chk("t4_busy", 32'(busy), 32'h0);
`ifdef SPI_SLAVE_STATUS_EN
        chk("t4_abort", 32'(abort_cnt - ab0), 32'd1);
`endif
        preload(8'h69);
        rx0 = rx_cnt;
        start_frame();
        xfer(8'h96, 8, 1'b1, got);
        end_frame();
        chk("t4_miso_byte", 32'(got), 32'h69);
        chk("t4_rx_count2", 32'(rx_cnt - rx0), 32'd1);
        chk("t4_rx_data", 32'(rx_hist[rx0]), 32'h96);

        // Asynchronous reset mid-byte
        preload(8'h77);
        start_frame();
        xfer(8'hAA, 3, 1'b0, got);
        rst_n = 1'b0;
        #1;
        chk("t5_miso", 32'(miso), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_tx_ready", 32'(tx_ready), 32'h1);
        chk("t5_rx_valid", 32'(rx_valid), 32'h0);
        chk("t5_rx_data", 32'(rx_data), 32'h00);
        sclk = 1'b0;
        ss_n = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        preload(8'h5A);
        rx0 = rx_cnt;
        start_frame();
        xfer(8'hE7, 8, 1'b1, got);
        end_frame();
        chk("t5_miso_byte", 32'(got), 32'h5A);
        chk("t5_rx_data2", 32'(rx_hist[rx0]), 32'hE7);

        // SCLK activity with SS_N high is ignored
        preload(8'hC3);
        rx0 = rx_cnt;
        watch = 1'b1;
        repeat (8) begin
            sclk = 1'b1;
            cyc(4);
            sclk = 1'b0;
            cyc(4);
        end
        cyc(6);
        watch = 1'b0;
        chk("t6_rx_count", 32'(rx_cnt - rx0), 32'd0);
        chk("t6_miso_high", 32'(miso_hi), 32'd0);
        chk("t6_tx_ready", 32'(tx_ready), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        start_frame();
        xfer(8'h81, 8, 1'b1, got);
        end_frame();
        chk("t6_miso_byte", 32'(got), 32'hC3);
        chk("t6_rx_data", 32'(rx_hist[rx0]), 32'h81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
